// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares the single SRAM_Controller port between three requesters:
//   port 0 = VGA read-back (fixed highest priority), port 1 = colourspace
//   converter, port 2 = decoder/IDCT engine (ports 1/2 round-robin).
//   A granted port may hold the SRAM for up to LOCK_MAX consecutive cycles
//   by keeping lock_i asserted. At most one access is issued per clock. The
//   controller inputs are registered, and each read returns with a one-hot
//   per-port valid strobe.
//
// Ports
//   Clock_50         system clock, rising edge
//   Reset            synchronous, active-high reset
//   req_i[2:0]       per-port request
//   lock_i[2:0]      per-port burst lock (only meaningful with req_i)
//   we_n_i[2:0]      per-port write enable, active low (1 = read)
//   addr_i[2:0]      per-port 18-bit SRAM word address
//   wdata_i[2:0]     per-port 16-bit write data
//   gnt_o[2:0]       one-hot grant, combinational
//   rvalid_o[2:0]    one-hot read-data valid
//   rdata_o          read data (SRAM_read_data passed through)
//   SRAM_address     registered address to SRAM_Controller
//   SRAM_write_data  registered write data to SRAM_Controller
//   SRAM_we_n        registered write enable to SRAM_Controller
//   SRAM_read_data   read data from SRAM_Controller
//   SRAM_ready       controller ready; no grants while low
module sram_port_arbiter #(
    parameter int LOCK_MAX   = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic              Clock_50,
    input  logic              Reset,
    input  logic [2:0]        req_i,
    input  logic [2:0]        lock_i,
    input  logic [2:0]        we_n_i,
    input  logic [2:0][17:0]  addr_i,
    input  logic [2:0][15:0]  wdata_i,
    output logic [2:0]        gnt_o,
    output logic [2:0]        rvalid_o,
    output logic [15:0]       rdata_o,
    output logic [17:0]       SRAM_address,
    output logic [15:0]       SRAM_write_data,
    output logic              SRAM_we_n,
    input  logic [15:0]       SRAM_read_data,
    input  logic              SRAM_ready
);

    localparam logic [7:0] LOCK_CNT_MAX = 8'(LOCK_MAX);

    // Which of ports 1/2 wins when both request.
    typedef enum logic {RR_PORT1 = 1'b0, RR_PORT2 = 1'b1} rr_e;

    rr_e        rr_ptr, rr_ptr_n;
    logic       lock_valid, lock_valid_n;
    logic [1:0] lock_owner, lock_owner_n;
    logic [7:0] lock_cnt, lock_cnt_n;

    logic       owner_hit;
    logic       gnt_any;
    logic [1:0] gnt_port;

    // Read-tag pipeline: {valid, port} travels alongside the address.
    logic       tag_valid [RD_LATENCY];
    logic [1:0] tag_port  [RD_LATENCY];

    assign rdata_o = SRAM_read_data;

    // Arbitration.
    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_port  = 2'd0;
        owner_hit = lock_valid && req_i[lock_owner] && (lock_cnt < LOCK_CNT_MAX);
        if (!Reset && SRAM_ready) begin
            if (owner_hit) begin
                gnt_any  = 1'b1;
                gnt_port = lock_owner;
            end else if (req_i[0]) begin
                gnt_any  = 1'b1;
                gnt_port = 2'd0;
            end else if (req_i[1] && req_i[2]) begin
                gnt_any  = 1'b1;
                gnt_port = (rr_ptr == RR_PORT1) ? 2'd1 : 2'd2;
            end else if (req_i[1]) begin
                gnt_any  = 1'b1;
                gnt_port = 2'd1;
            end else if (req_i[2]) begin
                gnt_any  = 1'b1;
                gnt_port = 2'd2;
            end
        end
        gnt_o = gnt_any ? (3'b001 << gnt_port) : 3'b000;
    end

    // Lock ownership and round-robin pointer update.
    always_comb begin
        rr_ptr_n     = rr_ptr;
        lock_valid_n = lock_valid;
        lock_owner_n = lock_owner;
        lock_cnt_n   = lock_cnt;

        // Owner released as soon as it drops its request or its lock.
        if (lock_valid && (!req_i[lock_owner] || !lock_i[lock_owner])) begin
            lock_valid_n = 1'b0;
            lock_cnt_n   = 8'd0;
        end

        if (gnt_any) begin
            // A served port 1/2 always leaves the pointer on the other one,
            // which also covers the "point away after lock expiry" case.
            if (gnt_port == 2'd1)
                rr_ptr_n = RR_PORT2;
            else if (gnt_port == 2'd2)
                rr_ptr_n = RR_PORT1;

            if (lock_i[gnt_port]) begin
                if (owner_hit) begin
                    if (lock_cnt + 8'd1 == LOCK_CNT_MAX) begin
                        lock_valid_n = 1'b0;
                        lock_cnt_n   = 8'd0;
                    end else begin
                        lock_cnt_n   = lock_cnt + 8'd1;
                    end
                end else begin
                    lock_valid_n = 1'b1;
                    lock_owner_n = gnt_port;
                    lock_cnt_n   = 8'd1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            rr_ptr          <= RR_PORT1;
            lock_valid      <= 1'b0;
            lock_owner      <= 2'd0;
            lock_cnt        <= 8'd0;
            SRAM_address    <= 18'd0;
            SRAM_write_data <= 16'd0;
            SRAM_we_n       <= 1'b1;
            rvalid_o        <= 3'b000;
            // NOTE: the tag pipeline is reset (unlike a data array) because
            // a stale valid bit would raise rvalid_o for a dropped read.
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_valid[i] <= 1'b0;
                tag_port[i]  <= 2'd0;
            end
        end else begin
            rr_ptr     <= rr_ptr_n;
            lock_valid <= lock_valid_n;
            lock_owner <= lock_owner_n;
            lock_cnt   <= lock_cnt_n;

            if (gnt_any) begin
                SRAM_address    <= addr_i[gnt_port];
                SRAM_write_data <= wdata_i[gnt_port];
                SRAM_we_n       <= we_n_i[gnt_port];
            end else begin
                SRAM_we_n       <= 1'b1;
            end

            // Writes and idle cycles push an invalid tag.
            tag_valid[0] <= gnt_any && we_n_i[gnt_port];
            tag_port[0]  <= gnt_port;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_port[i]  <= tag_port[i-1];
            end

            rvalid_o <= tag_valid[RD_LATENCY-1] ? (3'b001 << tag_port[RD_LATENCY-1]) : 3'b000;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed testbench for sram_port_arbiter (LOCK_MAX=4, RD_LATENCY=2).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge. A small SRAM model returns data RD_LATENCY cycles
// after the address appears.
module tb_sram_port_arbiter;

    logic             Clock_50;
    logic             Reset;
    logic [2:0]       req_i;
    logic [2:0]       lock_i;
    logic [2:0]       we_n_i;
    logic [2:0][17:0] addr_i;
    logic [2:0][15:0] wdata_i;
    logic [2:0]       gnt_o;
    logic [2:0]       rvalid_o;
    logic [15:0]      rdata_o;
    logic [17:0]      SRAM_address;
    logic [15:0]      SRAM_write_data;
    logic             SRAM_we_n;
    logic [15:0]      SRAM_read_data;
    logic             SRAM_ready;

    int total = 0;
    int bad   = 0;

    sram_port_arbiter #(.LOCK_MAX(4), .RD_LATENCY(2)) dut (
        .Clock_50        (Clock_50),
        .Reset           (Reset),
        .req_i           (req_i),
        .lock_i          (lock_i),
        .we_n_i          (we_n_i),
        .addr_i          (addr_i),
        .wdata_i         (wdata_i),
        .gnt_o           (gnt_o),
        .rvalid_o        (rvalid_o),
        .rdata_o         (rdata_o),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .SRAM_read_data  (SRAM_read_data),
        .SRAM_ready      (SRAM_ready)
    );

    initial Clock_50 = 1'b0;
    always #5 Clock_50 = ~Clock_50;

    // SRAM model: data follows the address by two clock cycles.
    logic [17:0] mdl_d1, mdl_d2;
    always @(posedge Clock_50) begin
        mdl_d1 <= SRAM_address;
        mdl_d2 <= mdl_d1;
    end
    assign SRAM_read_data = (mdl_d2 == 18'd38400) ? 16'h80A0 : (mdl_d2[15:0] ^ 16'h5A5A);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge Clock_50);
        #1;
    endtask

    task automatic sample();
        @(negedge Clock_50);
    endtask

    task automatic idle(input int n);
        req_i  = 3'b000;
        lock_i = 3'b000;
        we_n_i = 3'b111;
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    logic [2:0] exp_rr [8];

    initial begin
        exp_rr = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b010, 3'b100};

        Reset      = 1'b1;
        SRAM_ready = 1'b1;
        req_i      = 3'b111;
        lock_i     = 3'b000;
        we_n_i     = 3'b111;
        addr_i     = '0;
        wdata_i    = '0;

        // Reset held two cycles with all ports requesting.
        for (int c = 0; c < 2; c++) begin
            sample();
            check("rst_gnt",    32'(gnt_o),        32'h0);
            check("rst_we_n",   32'(SRAM_we_n),    32'h1);
            check("rst_addr",   32'(SRAM_address), 32'h0);
            check("rst_rvalid", 32'(rvalid_o),     32'h0);
            next_cycle();
        end
        Reset = 1'b0;

        // Fixed priority for port 0, then round-robin between ports 1/2.
        addr_i[0] = 18'd10; addr_i[1] = 18'd11; addr_i[2] = 18'd12;
        for (int c = 0; c < 8; c++) begin
            req_i = (c < 4) ? 3'b111 : 3'b110;
            sample();
            check($sformatf("rr_gnt%0d", c), 32'(gnt_o), 32'(exp_rr[c]));
            next_cycle();
        end
        idle(4);

        // Port 1 read of 38400; data back three cycles after the grant.
        req_i = 3'b010; addr_i[1] = 18'd38400; we_n_i = 3'b111;
        sample();
        check("rd_gnt", 32'(gnt_o), 32'b010);
        next_cycle();
        req_i = 3'b000;
        sample();
        check("rd_addr",    32'(SRAM_address), 32'd38400);
        check("rd_rvalid1", 32'(rvalid_o),     32'h0);
        next_cycle();
        sample();
        check("rd_rvalid2", 32'(rvalid_o), 32'h0);
        next_cycle();
        sample();
        check("rd_rvalid3", 32'(rvalid_o), 32'b010);
        check("rd_rdata",   32'(rdata_o),  32'h80A0);
        next_cycle();
        sample();
        check("rd_rvalid4", 32'(rvalid_o), 32'h0);
        idle(3);

        // Lock: port 1 holds the SRAM for LOCK_MAX=4 cycles, then port 0.
        for (int c = 0; c < 6; c++) begin
            req_i  = (c == 0) ? 3'b010 : 3'b011;
            lock_i = 3'b010;
            sample();
            if (c < 4)
                check($sformatf("lock_gnt%0d", c), 32'(gnt_o), 32'b010);
            else
                check($sformatf("lock_gnt%0d", c), 32'(gnt_o), 32'b001);
            next_cycle();
        end
        idle(5);

        // Port 2 write: one-cycle SRAM_we_n pulse, no read strobe.
        req_i = 3'b100; we_n_i = 3'b011; addr_i[2] = 18'd146944; wdata_i[2] = 16'hABCD;
        sample();
        check("wr_gnt", 32'(gnt_o), 32'b100);
        next_cycle();
        idle(0);
        sample();
        check("wr_we_n1",  32'(SRAM_we_n),       32'h0);
        check("wr_addr",   32'(SRAM_address),    32'd146944);
        check("wr_wdata",  32'(SRAM_write_data), 32'hABCD);
        check("wr_rvalid1", 32'(rvalid_o),       32'h0);
        next_cycle();
        sample();
        check("wr_we_n2",   32'(SRAM_we_n), 32'h1);
        check("wr_rvalid2", 32'(rvalid_o),  32'h0);
        next_cycle();
        sample();
        check("wr_rvalid3", 32'(rvalid_o), 32'h0);
        idle(3);

        // Port 0 read, then Reset pulsed: the in-flight read is dropped.
        req_i = 3'b001; addr_i[0] = 18'd100; we_n_i = 3'b111;
        sample();
        check("mrst_gnt", 32'(gnt_o), 32'b001);
        next_cycle();
        req_i = 3'b000; Reset = 1'b1;
        sample();
        check("mrst_gnt_rst", 32'(gnt_o), 32'h0);
        next_cycle();
        Reset = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            sample();
            check($sformatf("mrst_rvalid%0d", c), 32'(rvalid_o), 32'h0);
            if (c == 2) begin
                check("mrst_we_n", 32'(SRAM_we_n),    32'h1);
                check("mrst_addr", 32'(SRAM_address), 32'h0);
            end
            next_cycle();
        end

        // SRAM_ready low: no grants, but the in-flight read still returns.
        req_i = 3'b010; addr_i[1] = 18'd500; we_n_i = 3'b111;
        sample();
        check("rdy_gnt0", 32'(gnt_o), 32'b010);
        next_cycle();
        SRAM_ready = 1'b0; req_i = 3'b111;
        sample();
        check("rdy_gnt1", 32'(gnt_o), 32'h0);
        next_cycle();
        sample();
        check("rdy_gnt2",   32'(gnt_o),    32'h0);
        check("rdy_rvalid2", 32'(rvalid_o), 32'h0);
        next_cycle();
        sample();
        check("rdy_gnt3",   32'(gnt_o),    32'h0);
        check("rdy_rvalid3", 32'(rvalid_o), 32'b010);
        check("rdy_rdata",  32'(rdata_o),  32'h5BAE);
        next_cycle();
        sample();
        check("rdy_rvalid4", 32'(rvalid_o), 32'h0);
        check("rdy_we_n",    32'(SRAM_we_n), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
